// File: rtl/microcode_sequencer_pkg.sv
// uSEQ_PKG: shared encodings for the ARC control-store address sequencer.
// Condition-field codes, sequencer FSM states, decode base and PSR bit positions.
package uSEQ_PKG;

    // Microword condition field encodings
    localparam logic [2:0] COND_NEXT   = 3'b000;
    localparam logic [2:0] COND_N      = 3'b001;
    localparam logic [2:0] COND_Z      = 3'b010;
    localparam logic [2:0] COND_V      = 3'b011;
    localparam logic [2:0] COND_C      = 3'b100;
    localparam logic [2:0] COND_IR13   = 3'b101;
    localparam logic [2:0] COND_JUMP   = 3'b110;
    localparam logic [2:0] COND_DECODE = 3'b111;

    // Sequencer states: free-running or held on a memory handshake
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MEMWAIT = 1'b1
    } seqState_t;

    // Leading bit of a decoded opcode address (decode table lives at 1024..2047)
    localparam logic DECODE_BASE = 1'b1;

    // Bit positions inside the {N,Z,V,C} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/microcode_sequencer_nextaddr.sv
// uSEQ_NEXTADDR: combinational next control-store address selection.
// Chooses between microPC+1, the jump field and the opcode decode address.
module uSEQ_NEXTADDR
    import uSEQ_PKG::*;
#(
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int DATAWIDTH_IR          = 32,
    parameter int DATAWIDTH_FLAGS       = 4
) (
    input  logic [DATAWIDTH_CONDITION-1:0]   uNA_Condition_InBus,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] uNA_JumpAddress_InBus,
    input  logic [DATAWIDTH_IR-1:0]          uNA_IR_InBus,
    input  logic [DATAWIDTH_FLAGS-1:0]       uNA_PSRFlags_InBus,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] uNA_MicroPC_InBus,
    output logic [DATAWIDTH_JUMPADDRESS-1:0] uNA_NextAddress_OutBus
);

    logic [DATAWIDTH_JUMPADDRESS-1:0] incAddress;
    logic [DATAWIDTH_JUMPADDRESS-1:0] decodeAddress;
    logic                             unusedIrBits;

    // Sequential successor; 11-bit addition wraps 2047 -> 0 by itself
    assign incAddress = uNA_MicroPC_InBus + 1'b1;

    // Opcode decode: op (IR[31:30]) and op3 (IR[24:19]) index a 4-word slot table
    assign decodeAddress = {DECODE_BASE, uNA_IR_InBus[31:30], uNA_IR_InBus[24:19], 2'b00};

    // IR fields the sequencer never looks at
    assign unusedIrBits = ^{uNA_IR_InBus[29:25], uNA_IR_InBus[18:14], uNA_IR_InBus[12:0]};

    // Select the next address from the condition field
    always_comb begin
        uNA_NextAddress_OutBus = incAddress;
        unique case (uNA_Condition_InBus)
            COND_NEXT:   uNA_NextAddress_OutBus = incAddress;
            COND_N:      if (uNA_PSRFlags_InBus[FLAG_N]) uNA_NextAddress_OutBus = uNA_JumpAddress_InBus;
            COND_Z:      if (uNA_PSRFlags_InBus[FLAG_Z]) uNA_NextAddress_OutBus = uNA_JumpAddress_InBus;
            COND_V:      if (uNA_PSRFlags_InBus[FLAG_V]) uNA_NextAddress_OutBus = uNA_JumpAddress_InBus;
            COND_C:      if (uNA_PSRFlags_InBus[FLAG_C]) uNA_NextAddress_OutBus = uNA_JumpAddress_InBus;
            COND_IR13:   if (uNA_IR_InBus[13])           uNA_NextAddress_OutBus = uNA_JumpAddress_InBus;
            COND_JUMP:   uNA_NextAddress_OutBus = uNA_JumpAddress_InBus;
            COND_DECODE: uNA_NextAddress_OutBus = decodeAddress;
            default:     uNA_NextAddress_OutBus = incAddress;
        endcase
    end

endmodule

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: ARC control-store address sequencer.
// Holds the microPC and PSR flags, stalls on memory handshakes and
// advances one microword per clock otherwise.
module microcode_sequencer
    import uSEQ_PKG::*;
#(
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int DATAWIDTH_IR          = 32,
    parameter int DATAWIDTH_FLAGS       = 4
) (
    input  logic                             uSEQ_CLOCK_50,
    input  logic                             MICROCODE_STORE_ResetInHigh_In,
    input  logic [DATAWIDTH_CONDITION-1:0]   uSEQ_Condition_InBus,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] uSEQ_JumpAddress_InBus,
    input  logic [DATAWIDTH_IR-1:0]          uSEQ_IR_InBus,
    input  logic                             uSEQ_RD_In,
    input  logic                             uSEQ_WR_In,
    input  logic                             uSEQ_MemReady_In,
    input  logic [DATAWIDTH_FLAGS-1:0]       uSEQ_ALUFlags_InBus,
    input  logic                             uSEQ_FlagLoad_In,
    output logic [DATAWIDTH_JUMPADDRESS-1:0] uSEQ_CSAddress_OutBus,
    output logic [DATAWIDTH_FLAGS-1:0]       uSEQ_PSRFlags_OutBus,
    output logic                             uSEQ_MemWait_Out
);

    seqState_t                        stateReg;
    seqState_t                        stateNext;
    logic [DATAWIDTH_JUMPADDRESS-1:0] microPcReg;
    logic [DATAWIDTH_JUMPADDRESS-1:0] nextAddress;
    logic [DATAWIDTH_FLAGS-1:0]       psrReg;
    logic                             retire;
    logic                             memWait;

    // Next address is always computed from the pre-update PSR, so a
    // flag branch in a flag-loading microword sees the old flags.
    uSEQ_NEXTADDR #(
        .DATAWIDTH_JUMPADDRESS (DATAWIDTH_JUMPADDRESS),
        .DATAWIDTH_CONDITION   (DATAWIDTH_CONDITION),
        .DATAWIDTH_IR          (DATAWIDTH_IR),
        .DATAWIDTH_FLAGS       (DATAWIDTH_FLAGS)
    ) uNextAddr (
        .uNA_Condition_InBus    (uSEQ_Condition_InBus),
        .uNA_JumpAddress_InBus  (uSEQ_JumpAddress_InBus),
        .uNA_IR_InBus           (uSEQ_IR_InBus),
        .uNA_PSRFlags_InBus     (psrReg),
        .uNA_MicroPC_InBus      (microPcReg),
        .uNA_NextAddress_OutBus (nextAddress)
    );

    // FSM next state and retire decision; a retiring microword advances microPC and may load flags
    always_comb begin
        stateNext = stateReg;
        retire    = 1'b0;
        memWait   = 1'b0;
        unique case (stateReg)
            ST_RUN: begin
                if ((uSEQ_RD_In || uSEQ_WR_In) && !uSEQ_MemReady_In) begin
                    stateNext = ST_MEMWAIT;
                end else begin
                    retire = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                // Held until MemReady, even if RD/WR drop (no recovery but reset)
                memWait = 1'b1;
                if (uSEQ_MemReady_In) begin
                    stateNext = ST_RUN;
                    retire    = 1'b1;
                end
            end
            default: begin
                stateNext = ST_RUN;
            end
        endcase
    end

    // State, microPC and PSR registers
    always_ff @(posedge uSEQ_CLOCK_50 or posedge MICROCODE_STORE_ResetInHigh_In) begin
        if (MICROCODE_STORE_ResetInHigh_In) begin
            stateReg   <= ST_RUN;
            microPcReg <= '0;
            psrReg     <= '0;
        end else begin
            stateReg <= stateNext;
            if (retire) begin
                microPcReg <= nextAddress;
                if (uSEQ_FlagLoad_In) begin
                    psrReg <= uSEQ_ALUFlags_InBus;
                end
            end
        end
    end

    assign uSEQ_CSAddress_OutBus = microPcReg;
    assign uSEQ_PSRFlags_OutBus  = psrReg;
    assign uSEQ_MemWait_Out      = memWait;

endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Control-store address sequencer for the ARC micro-datapath. Every clock it computes the next control-store address from the condition and jump fields of the current microword, the instruction register and the latched PSR flags, and drives it into the microcode store's address input. It also holds the sequence during main-memory handshakes and latches the N/Z/V/C flags produced by the ALU.

## Interface
Parameters:
- DATAWIDTH_JUMPADDRESS, 11, width of control-store address and jump field
- DATAWIDTH_CONDITION, 3, width of microword condition field
- DATAWIDTH_IR, 32, instruction register width
- DATAWIDTH_FLAGS, 4, PSR flag vector {N,Z,V,C}

Ports:
- uSEQ_CLOCK_50  in  1  system clock; all state updates on rising edge
- MICROCODE_STORE_ResetInHigh_In  in  1  reset, asynchronous, active-high
- uSEQ_Condition_InBus  in  3  condition field of current microword
- uSEQ_JumpAddress_InBus  in  11  jump field of current microword
- uSEQ_IR_InBus  in  32  current instruction register contents
- uSEQ_RD_In  in  1  current microword requests memory read
- uSEQ_WR_In  in  1  current microword requests memory write
- uSEQ_MemReady_In  in  1  memory completes the request this cycle
- uSEQ_ALUFlags_InBus  in  4  {N,Z,V,C} from ALU, current cycle
- uSEQ_FlagLoad_In  in  1  current microword is a cc-setting ALU op
- uSEQ_CSAddress_OutBus  out  11  registered control-store address (microPC)
- uSEQ_PSRFlags_OutBus  out  4  latched {N,Z,V,C}
- uSEQ_MemWait_Out  out  1  high while sequencer holds for memory

## Operation
- FSM states: RUN, MEMWAIT. Reset state RUN.
- RUN: if (RD|WR) and !MemReady -> MEMWAIT, microPC held, no flag load. Otherwise microPC <= next address, flags updated if FlagLoad.
- MEMWAIT: microPC held, MemWait=1. When MemReady=1 -> RUN, microPC <= next address (same microword). RD/WR dropping while in MEMWAIT without MemReady: stay held (protocol violation, no recovery path other than reset).
- Next address by condition field:
  - 000: microPC+1
  - 001/010/011/100: jump if N/Z/V/C (latched PSR) set, else microPC+1
  - 101: jump if IR[13], else microPC+1
  - 110: unconditional jump
  - 111: decode, {1'b1, IR[31:30], IR[24:19], 2'b00}; e.g. addcc (op=10, op3=010000) -> 1600, subcc (op3=010100) -> 1616
- microPC+1 wraps 2047 -> 0, no error flag.
- Flag load: PSR <= ALUFlags on rising edge when FlagLoad=1 and the microword retires (RUN without stall, or MEMWAIT with MemReady).
- Flag branch and flag load in the same microword: branch uses PSR value before the update.

## Timing
- Reset values: CSAddress=0, PSRFlags=0000, MemWait=0, state RUN. Asserted asynchronously; release synchronous to next rising edge.
- microPC updates on rising edge; microcode store registers microword on following falling edge; next rising edge consumes it. Throughput one microinstruction per clock when no stall.
- Address 0 after reset: first microword (fetch) is valid after first falling edge.
- MemWait is combinational from state, asserted the cycle after the stall is detected; for a request with MemReady already high, zero wait cycles.
- Reset mid-MEMWAIT: immediate return to RUN, address 0, flags cleared.

## Structure
- Shared package uSEQ_PKG: condition encodings (COND_NEXT, COND_N, COND_Z, COND_V, COND_C, COND_IR13, COND_JUMP, COND_DECODE), FSM state encodings, decode base constant 1'b1 and flag bit indices.
- One sub-module: uSEQ_NEXTADDR, purely combinational next-address mux (condition, jump, IR, flags, microPC -> next address). Top holds FSM, microPC and PSR registers.

## Test plan
- Reset pulse mid-run -> CSAddress=0, PSRFlags=0000, MemWait=0 immediately; condition 000 for 3 clocks -> 1,2,3.
- Condition 111 with IR op=10 op3=010000 -> next address 1600; op3=010100 -> 1616.
- Condition 101, jump 1692: IR[13]=1 -> 1692; IR[13]=0 -> microPC+1.
- RD=1, MemReady low for 3 cycles -> address held, MemWait high 3 cycles, then advances once MemReady=1; flags untouched during hold.
- FlagLoad=1 with ALUFlags=0100 and condition 010 in same word, PSR=0000 -> no jump; following word condition 010 -> jump taken.
- microPC=2047, condition 000 -> 0.
